// File: rtl/gf180mcu_fd_io__ring_pkg.sv
// Shared types and defaults for the GF180MCU pad-ring power-up sequencer.
package gf180mcu_fd_io__ring_pkg;

  localparam int N_GRP_DEF       = 4;
  localparam int DLY_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_PG = 3'd1,
    RAMP_UP = 3'd2,
    ON      = 3'd3,
    RAMP_DN = 3'd4,
    FLT     = 3'd5
  } ring_state_e;

  function automatic logic is_busy(ring_state_e s);
    return (s == WAIT_PG) || (s == RAMP_UP) || (s == RAMP_DN);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_io__sync_rn.sv
// Multi-flop synchronizer for an asynchronous level, cleared by async active-low reset.
module gf180mcu_fd_io__sync_rn #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_io__ring_seq.sv
// Pad-ring power sequencer: enables pad groups one at a time after supplies are good,
// tears down in reverse on STOP, and drops everything at once on supply loss.
module gf180mcu_fd_io__ring_seq
  import gf180mcu_fd_io__ring_pkg::*;
#(
  parameter int N_GRP       = N_GRP_DEF,
  parameter int DLY_W       = DLY_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             VDD_OK,
  input  logic             DVDD_OK,
  input  logic             START,
  input  logic             STOP,
  input  logic             FAULT_CLR,
  input  logic [DLY_W-1:0] DLY,
  output logic [N_GRP-1:0] GRP_EN,
  output logic             READY,
  output logic             BUSY,
  output logic             FAULT
);

  localparam int IDX_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_GRP - 1);

  logic vdd_s, dvdd_s, vok;

  gf180mcu_fd_io__sync_rn #(.STAGES(SYNC_STAGES)) u_sync_vdd (
    .clk(CLK), .rst_n(RN), .d(VDD_OK), .q(vdd_s)
  );
  gf180mcu_fd_io__sync_rn #(.STAGES(SYNC_STAGES)) u_sync_dvdd (
    .clk(CLK), .rst_n(RN), .d(DVDD_OK), .q(dvdd_s)
  );

  assign vok = vdd_s & dvdd_s;

  ring_state_e      state_q, state_d;
  logic [N_GRP-1:0] grp_en_q, grp_en_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    grp_en_d = grp_en_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          state_d = WAIT_PG;
          dly_d   = DLY;
        end
      end
      WAIT_PG: begin
        if (STOP) state_d = IDLE;
        else if (vok) begin
          state_d = RAMP_UP;
          cnt_d   = dly_q;
          idx_d   = '0;
        end
      end
      RAMP_UP: begin
        if (!vok) begin
          state_d  = FLT;
          grp_en_d = '0;
        end else if (STOP) begin
          // reverse from the current idx; that bit may not be set yet, clearing it is harmless
          state_d = RAMP_DN;
          cnt_d   = dly_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          grp_en_d[idx_q] = 1'b1;
          cnt_d           = dly_q;
          if (idx_q == IDX_LAST) state_d = ON;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ON: begin
        if (!vok) begin
          state_d  = FLT;
          grp_en_d = '0;
        end else if (STOP) begin
          state_d = RAMP_DN;
          cnt_d   = dly_q;
          idx_d   = IDX_LAST;
        end
      end
      RAMP_DN: begin
        if (!vok) begin
          state_d  = FLT;
          grp_en_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLY_W'(1);
        end else begin
          grp_en_d[idx_q] = 1'b0;
          cnt_d           = dly_q;
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      FLT: begin
        grp_en_d = '0;
        if (FAULT_CLR) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        grp_en_d = '0;
      end
    endcase
    // status flags are decoded from the next state so they move on the same edge as it
    ready_d = (state_d == ON);
    busy_d  = is_busy(state_d);
    fault_d = (state_d == FLT);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      grp_en_q <= '0;
      dly_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_en_q <= grp_en_d;
      dly_q    <= dly_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign GRP_EN = grp_en_q;
  assign READY  = ready_q;
  assign BUSY   = busy_q;
  assign FAULT  = fault_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__ring_seq.sv
// Scoreboard bench for the pad-ring sequencer: stimulus queues expected output changes,
// a monitor pops one per observed change and checks value and spacing in cycles.
module tb_gf180mcu_fd_io__ring_seq;

  logic       CLK = 1'b0;
  logic       RN;
  logic       VDD_OK = 1'b1, DVDD_OK = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, FAULT_CLR = 1'b0;
  logic [7:0] DLY = '0;
  logic [3:0] GRP_EN;
  logic       READY, BUSY, FAULT;

  gf180mcu_fd_io__ring_seq #(.N_GRP(4), .DLY_W(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RN(RN), .VDD_OK(VDD_OK), .DVDD_OK(DVDD_OK),
    .START(START), .STOP(STOP), .FAULT_CLR(FAULT_CLR), .DLY(DLY),
    .GRP_EN(GRP_EN), .READY(READY), .BUSY(BUSY), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] v;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] pk(logic [3:0] g, logic r, logic b, logic f);
    return {g, r, b, f};
  endfunction

  task automatic push(logic [6:0] v, int gap);
    exp_t e;
    e.v   = v;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: every change of {GRP_EN,READY,BUSY,FAULT} must match the next queued entry
  initial begin
    logic [6:0] prev, cur;
    int cyc, last, ev;
    exp_t e;
    prev = '0; cyc = 0; last = 0; ev = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      cur = {GRP_EN, READY, BUSY, FAULT};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change ev%0d act=%b exp=none", ev, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v) begin
            errors++;
            $display("FAIL ev%0d_outputs act=%b exp=%b (grp,rdy,bsy,flt)", ev, cur, e.v);
          end
          if (e.gap >= 0) begin
            checks++;
            if (cyc - last != e.gap) begin
              errors++;
              $display("FAIL ev%0d_spacing act=%0d exp=%0d cycles", ev, cyc - last, e.gap);
            end
          end
        end
        ev++;
        prev = cur;
        last = cyc;
      end
    end
  end

  task automatic bringup(int d);
    @(negedge CLK);
    DLY = 8'(d); START = 1'b1;
    push(pk(4'b0000, 0, 1, 0), -1);
    push(pk(4'b0001, 0, 1, 0), d + 2);
    push(pk(4'b0011, 0, 1, 0), d + 1);
    push(pk(4'b0111, 0, 1, 0), d + 1);
    push(pk(4'b1111, 1, 0, 0), d + 1);
    repeat (4 * (d + 1) + 4) @(negedge CLK);
  endtask

  task automatic teardown(int d);
    @(negedge CLK);
    STOP = 1'b1; START = 1'b0;
    push(pk(4'b1111, 0, 1, 0), -1);
    push(pk(4'b0111, 0, 1, 0), d + 1);
    push(pk(4'b0011, 0, 1, 0), d + 1);
    push(pk(4'b0001, 0, 1, 0), d + 1);
    push(pk(4'b0000, 0, 0, 0), d + 1);
    @(negedge CLK);
    STOP = 1'b0;
    repeat (4 * (d + 1) + 3) @(negedge CLK);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_grp"}, int'(GRP_EN), 0);
    chk({nm, "_ready"}, int'(READY), 0);
    chk({nm, "_busy"}, int'(BUSY), 0);
    chk({nm, "_fault"}, int'(FAULT), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RN = 1'b1;
    #1 RN = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(negedge CLK);
    RN = 1'b1;
    repeat (4) @(negedge CLK);

    bringup(3); teardown(3);
    bringup(0); teardown(0);
    bringup(2); teardown(2);

    // brown-out at GRP_EN=0011
    @(negedge CLK);
    DLY = 8'd3; START = 1'b1;
    push(pk(4'b0000, 0, 1, 0), -1);
    push(pk(4'b0001, 0, 1, 0), 5);
    push(pk(4'b0011, 0, 1, 0), 4);
    repeat (10) @(negedge CLK);
    DVDD_OK = 1'b0;
    push(pk(4'b0000, 0, 0, 1), 3);
    repeat (5) @(negedge CLK);
    DVDD_OK = 1'b1; START = 1'b0;
    repeat (3) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("flt_held", int'(FAULT), 1);
    FAULT_CLR = 1'b1;
    push(pk(4'b0000, 0, 0, 0), -1);
    @(negedge CLK);
    FAULT_CLR = 1'b0;
    repeat (4) @(negedge CLK);

    // STOP coinciding with supply loss in ON must fault
    bringup(1);
    @(negedge CLK);
    DVDD_OK = 1'b0; START = 1'b0;
    push(pk(4'b0000, 0, 0, 1), -1);
    @(negedge CLK);
    @(negedge CLK);
    STOP = 1'b1;
    @(negedge CLK);
    STOP = 1'b0;
    repeat (3) @(negedge CLK);
    DVDD_OK = 1'b1;
    repeat (3) @(negedge CLK);
    FAULT_CLR = 1'b1;
    push(pk(4'b0000, 0, 0, 0), -1);
    @(negedge CLK);
    FAULT_CLR = 1'b0;
    repeat (4) @(negedge CLK);

    // START with STOP in IDLE stays idle
    START = 1'b1; STOP = 1'b1;
    repeat (5) @(negedge CLK);
    chk("start_stop_idle_busy", int'(BUSY), 0);
    START = 1'b0; STOP = 1'b0;
    repeat (2) @(negedge CLK);

    // async reset mid-ramp
    DLY = 8'd3; START = 1'b1;
    push(pk(4'b0000, 0, 1, 0), -1);
    push(pk(4'b0001, 0, 1, 0), 5);
    repeat (7) @(negedge CLK);
    push(pk(4'b0000, 0, 0, 0), -1);
    #2 RN = 1'b0;
    #1 chk_zero("async_rst");
    START = 1'b0;
    @(negedge CLK);
    RN = 1'b1;
    repeat (6) @(negedge CLK);
    chk("post_rst_idle_busy", int'(BUSY), 0);
    bringup(1); teardown(1);

    repeat (3) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
